dp_ram_ctrl: RTL and testbench
==============================

// Module: dp_ram_ctrl
// PURPOSE
//  Requester-side controller driving both ports of dp_ram; sits between two client request channels and the RAM.
//  Accepts valid/ready requests per port, issues them to the RAM and returns 1-cycle-latency responses.
//  Never issues a same-address dual write: it serialises them with round-robin priority.
//  Forwards write data to a same-cycle reader of the same address.
// PARAMETERS
//  DATA_WIDTH  8   data width, matches dp_ram
//  ADDR_WIDTH  4   address width, matches dp_ram
//  CNT_WIDTH   16  width of saturating collision counter
// PORTS
//  clk            in   1           clock, all logic on posedge
//  rst            in   1           synchronous active-high reset
//  reqA_valid     in   1           port A request present
//  reqA_ready     out  1           port A request accepted this cycle when valid&ready
//  reqA_wr        in   1           1=write, 0=read
//  reqA_addr      in   ADDR_WIDTH  request address
//  reqA_wdata     in   DATA_WIDTH  write data
//  rspA_valid     out  1           port A response, 1-cycle pulse, no backpressure
//  rspA_rdata     out  DATA_WIDTH  read data (write: the written data)
//  reqB_*/rspB_*  same as A        port B channel
//  ram_wrA        out  1           to dp_ram wrA
//  ram_addrA      out  ADDR_WIDTH  to dp_ram addrA
//  ram_dataA_in   out  DATA_WIDTH  to dp_ram dataA_in
//  ram_dataA_out  in   DATA_WIDTH  from dp_ram dataA_out
//  ram_wrB/ram_addrB/ram_dataB_in/ram_dataB_out  same as A, port B
//  collision_cnt  out  CNT_WIDTH   count of serialised write collisions, saturating
// BEHAVIOUR
//  Reset (rst=1 at posedge): rspA/B_valid=0, collision_cnt=0, prio=A, fwd flags=0.
//   reqA/B_ready=0 while rst=1. Responses still in flight are dropped.
//  Collision: reqA_valid&reqB_valid&reqA_wr&reqB_wr&(reqA_addr==reqB_addr).
//   Only the prio port is ready; the other port's ready=0.
//   prio toggles after every collision cycle; collision_cnt+1, saturating at all-ones.
//   The stalled client holds its request; it wins next cycle if it collides again.
//  No collision: reqX_ready=1 for both ports (when not in reset).
//  RAM drive (combinational from acceptance):
//   ram_wrX = reqX_valid & reqX_ready & reqX_wr
//   ram_addrX = reqX_addr, ram_dataX_in = reqX_wdata
//   Unaccepted port: ram_wrX=0. Any read it causes is ignored.
//   Invariant: ram_wrA&ram_wrB&(ram_addrA==ram_addrB) is never 1.
//  Response: rspX_valid=1 exactly one cycle after acceptance on port X; 0 otherwise.
//   rspX_rdata = ram_dataX_out (write: RAM write-through, so = wdata).
//  Forwarding: port X accepts a read while port Y accepts a write to the same address in the same cycle.
//   Register fwdX=1 and fwd_dataX=reqY_wdata.
//   Next cycle rspX_rdata = fwd_dataX, not the stale RAM value. fwd flags clear every cycle unless re-set.
//  Read-read to the same address: both accepted, both return the RAM value.
//  Back-to-back accepts: a response every cycle per port; full throughput absent collisions.
//  rspX_rdata is don't-care when rspX_valid=0.
// TESTING
//  1. Reset, A wr addr3=0x5A, next cycle A rd addr3 -> rspA_valid pulses twice; second rdata=0x5A.
//  2. A,B both wr addr7 (A=0x11, B=0x22), prio=A, held valid.
//     -> cycle0 readyA=1/readyB=0; cycle1 B accepted; final mem[7]=0x22; collision_cnt=1.
//  3. Repeat collision with new data -> B wins first (prio toggled), A second; collision_cnt=2.
//  4. A wr addr2=0xC3 while B rd addr2 same cycle -> next cycle rspB_rdata=0xC3 (forwarded).
//  5. A,B both rd addr0 after wr 0x99 -> both rsp rdata=0x99 same cycle, no stall.
//  6. rst asserted the cycle after an accept -> rsp valids 0, collision_cnt=0, ready=0 during rst.
//  Bench checks the RAM-side invariant every cycle and never sees X on rsp rdata while valid.

Source files
------------

// File: rtl/dp_ram_ctrl.sv
// Requester-side controller for both ports of dp_ram: accepts client requests,
// serialises same-address dual writes round-robin and forwards same-cycle writes.
module dp_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqA_valid,
    output logic                  reqA_ready,
    input  logic                  reqA_wr,
    input  logic [ADDR_WIDTH-1:0] reqA_addr,
    input  logic [DATA_WIDTH-1:0] reqA_wdata,
    output logic                  rspA_valid,
    output logic [DATA_WIDTH-1:0] rspA_rdata,
    input  logic                  reqB_valid,
    output logic                  reqB_ready,
    input  logic                  reqB_wr,
    input  logic [ADDR_WIDTH-1:0] reqB_addr,
    input  logic [DATA_WIDTH-1:0] reqB_wdata,
    output logic                  rspB_valid,
    output logic [DATA_WIDTH-1:0] rspB_rdata,
    output logic                  ram_wrA,
    output logic [ADDR_WIDTH-1:0] ram_addrA,
    output logic [DATA_WIDTH-1:0] ram_dataA_in,
    input  logic [DATA_WIDTH-1:0] ram_dataA_out,
    output logic                  ram_wrB,
    output logic [ADDR_WIDTH-1:0] ram_addrB,
    output logic [DATA_WIDTH-1:0] ram_dataB_in,
    input  logic [DATA_WIDTH-1:0] ram_dataB_out,
    output logic [CNT_WIDTH-1:0]  collision_cnt
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e                 prio_q, prio_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  rsp_a_q, rsp_a_d;
    logic                  rsp_b_q, rsp_b_d;
    logic                  fwd_a_q, fwd_a_d;
    logic                  fwd_b_q, fwd_b_d;
    logic [DATA_WIDTH-1:0] fwd_data_a_q, fwd_data_a_d;
    logic [DATA_WIDTH-1:0] fwd_data_b_q, fwd_data_b_d;

    logic collide;
    logic same_addr;
    logic acc_a, acc_b;

    assign same_addr = (reqA_addr == reqB_addr);
    assign collide   = reqA_valid & reqB_valid & reqA_wr & reqB_wr & same_addr;

    always_comb begin
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        fwd_data_a_d = fwd_data_a_q;
        fwd_data_b_d = fwd_data_b_q;
        fwd_a_d      = 1'b0;
        fwd_b_d      = 1'b0;

        // Only the priority port may proceed on a same-address dual write
        reqA_ready = ~rst & (~collide | (prio_q == PRIO_A));
        reqB_ready = ~rst & (~collide | (prio_q == PRIO_B));

        acc_a   = reqA_valid & reqA_ready;
        acc_b   = reqB_valid & reqB_ready;
        rsp_a_d = acc_a;
        rsp_b_d = acc_b;

        if (collide) begin
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        // RAM is read-first across ports, so a same-cycle write must be forwarded
        if (acc_a & ~reqA_wr & acc_b & reqB_wr & same_addr) begin
            fwd_a_d      = 1'b1;
            fwd_data_a_d = reqB_wdata;
        end
        if (acc_b & ~reqB_wr & acc_a & reqA_wr & same_addr) begin
            fwd_b_d      = 1'b1;
            fwd_data_b_d = reqA_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q       <= PRIO_A;
            cnt_q        <= '0;
            rsp_a_q      <= 1'b0;
            rsp_b_q      <= 1'b0;
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_data_a_q <= '0;
            fwd_data_b_q <= '0;
        end else begin
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
            rsp_a_q      <= rsp_a_d;
            rsp_b_q      <= rsp_b_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            fwd_data_a_q <= fwd_data_a_d;
            fwd_data_b_q <= fwd_data_b_d;
        end
    end

    assign ram_wrA      = acc_a & reqA_wr;
    assign ram_addrA    = reqA_addr;
    assign ram_dataA_in = reqA_wdata;
    assign ram_wrB      = acc_b & reqB_wr;
    assign ram_addrB    = reqB_addr;
    assign ram_dataB_in = reqB_wdata;

    // In-flight responses are dropped as soon as reset is seen
    assign rspA_valid = rsp_a_q & ~rst;
    assign rspB_valid = rsp_b_q & ~rst;
    assign rspA_rdata = fwd_a_q ? fwd_data_a_q : ram_dataA_out;
    assign rspB_rdata = fwd_b_q ? fwd_data_b_q : ram_dataB_out;

    assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Bench for dp_ram_ctrl: behavioural read-first dual-port RAM, vector table,
// reference memory and per-port response scoreboard queues.
module tb_dp_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       reqA_valid, reqA_ready, reqA_wr;
    logic [3:0] reqA_addr;
    logic [7:0] reqA_wdata;
    logic       rspA_valid;
    logic [7:0] rspA_rdata;
    logic       reqB_valid, reqB_ready, reqB_wr;
    logic [3:0] reqB_addr;
    logic [7:0] reqB_wdata;
    logic       rspB_valid;
    logic [7:0] rspB_rdata;
    logic       ram_wrA, ram_wrB;
    logic [3:0] ram_addrA, ram_addrB;
    logic [7:0] ram_dataA_in, ram_dataB_in;
    logic [7:0] ram_dataA_out, ram_dataB_out;
    logic [15:0] collision_cnt;

    dp_ram_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .reqA_valid   (reqA_valid),
        .reqA_ready   (reqA_ready),
        .reqA_wr      (reqA_wr),
        .reqA_addr    (reqA_addr),
        .reqA_wdata   (reqA_wdata),
        .rspA_valid   (rspA_valid),
        .rspA_rdata   (rspA_rdata),
        .reqB_valid   (reqB_valid),
        .reqB_ready   (reqB_ready),
        .reqB_wr      (reqB_wr),
        .reqB_addr    (reqB_addr),
        .reqB_wdata   (reqB_wdata),
        .rspB_valid   (rspB_valid),
        .rspB_rdata   (rspB_rdata),
        .ram_wrA      (ram_wrA),
        .ram_addrA    (ram_addrA),
        .ram_dataA_in (ram_dataA_in),
        .ram_dataA_out(ram_dataA_out),
        .ram_wrB      (ram_wrB),
        .ram_addrB    (ram_addrB),
        .ram_dataB_in (ram_dataB_in),
        .ram_dataB_out(ram_dataB_out),
        .collision_cnt(collision_cnt)
    );

    always #5 clk = ~clk;

    // Read-first across ports, write-through on the writing port
    logic [7:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_wrA) ram_mem[ram_addrA] <= ram_dataA_in;
        if (ram_wrB) ram_mem[ram_addrB] <= ram_dataB_in;
        ram_dataA_out <= ram_wrA ? ram_dataA_in : ram_mem[ram_addrA];
        ram_dataB_out <= ram_wrB ? ram_dataB_in : ram_mem[ram_addrB];
    end

    typedef struct packed {
        logic       va;
        logic       wa;
        logic [3:0] aa;
        logic [7:0] da;
        logic       vb;
        logic       wb;
        logic [3:0] ab;
        logic [7:0] db;
        logic       ra;
        logic       rb;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] qA[$];
    logic [7:0] qB[$];
    logic [7:0] ref_mem [16];
    int         n_vec = 0;
    int         n_err = 0;
    logic [15:0] cnt_m = '0;

    function automatic vec_t mk(
        input logic va, input logic wa,
        input logic [3:0] aa, input logic [7:0] da,
        input logic vb, input logic wb,
        input logic [3:0] ab, input logic [7:0] db,
        input logic ra, input logic rb);
        vec_t v;
        v.va = va; v.wa = wa; v.aa = aa; v.da = da;
        v.vb = vb; v.wb = wb; v.ab = ab; v.db = db;
        v.ra = ra; v.rb = rb;
        return v;
    endfunction

    task automatic cmp(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input vec_t v, input logic r);
        logic       eA, eB, accA, accB;
        logic [7:0] d;
        @(posedge clk);
        #1;
        rst        = r;
        reqA_valid = v.va; reqA_wr = v.wa;
        reqA_addr  = v.aa; reqA_wdata = v.da;
        reqB_valid = v.vb; reqB_wr = v.wb;
        reqB_addr  = v.ab; reqB_wdata = v.db;
        @(negedge clk);
        // responses owed for the previous cycle
        cmp("rspA_valid", rspA_valid, !r && qA.size() > 0);
        if (qA.size() > 0) begin
            d = qA.pop_front();
            if (!r) cmp("rspA_rdata", rspA_rdata, d);
        end
        cmp("rspB_valid", rspB_valid, !r && qB.size() > 0);
        if (qB.size() > 0) begin
            d = qB.pop_front();
            if (!r) cmp("rspB_rdata", rspB_rdata, d);
        end
        eA = r ? 1'b0 : v.ra;
        eB = r ? 1'b0 : v.rb;
        cmp("reqA_ready", reqA_ready, eA);
        cmp("reqB_ready", reqB_ready, eB);
        cmp("ram_wrA", ram_wrA, v.va & eA & v.wa);
        cmp("ram_wrB", ram_wrB, v.vb & eB & v.wb);
        cmp("ram_inv", ram_wrA & ram_wrB & (ram_addrA == ram_addrB), 0);
        if (!r) cmp("collision_cnt", collision_cnt, cnt_m);
        if (r) begin
            cnt_m = '0;
        end else begin
            accA = v.va & eA;
            accB = v.vb & eB;
            if (accA) begin
                if (v.wa) d = v.da;
                else if (accB && v.wb && v.ab == v.aa) d = v.db;
                else d = ref_mem[v.aa];
                qA.push_back(d);
            end
            if (accB) begin
                if (v.wb) d = v.db;
                else if (accA && v.wa && v.aa == v.ab) d = v.da;
                else d = ref_mem[v.ab];
                qB.push_back(d);
            end
            if (accA && v.wa) ref_mem[v.aa] = v.da;
            if (accB && v.wb) ref_mem[v.ab] = v.db;
            if (v.va && v.vb && v.wa && v.wb && v.aa == v.ab
                && cnt_m != 16'hFFFF)
                cnt_m = cnt_m + 16'd1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // write then read back
        tbl.push_back(mk(1, 1, 3, 8'h5A, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 1));
        // collision, A has priority, B holds
        tbl.push_back(mk(1, 1, 7, 8'h11, 1, 1, 7, 8'h22, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 7, 8'h22, 1, 1));
        tbl.push_back(mk(1, 0, 7, 0, 0, 0, 0, 0, 1, 1));
        // collision again, B has priority now
        tbl.push_back(mk(1, 1, 7, 8'h33, 1, 1, 7, 8'h44, 0, 1));
        tbl.push_back(mk(1, 1, 7, 8'h33, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0, 1, 1));
        // stalled client wins a repeat collision
        tbl.push_back(mk(1, 1, 5, 8'h55, 1, 1, 5, 8'h66, 1, 0));
        tbl.push_back(mk(1, 1, 5, 8'h77, 1, 1, 5, 8'h66, 0, 1));
        tbl.push_back(mk(1, 1, 5, 8'h77, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 5, 0, 1, 1));
        // forwarding both directions, then fwd must clear
        tbl.push_back(mk(1, 1, 2, 8'hC3, 1, 0, 2, 0, 1, 1));
        tbl.push_back(mk(1, 0, 9, 0, 1, 1, 9, 8'hAB, 1, 1));
        tbl.push_back(mk(1, 1, 0, 8'h99, 1, 1, 1, 8'h42, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 1, 1));
        tbl.push_back(mk(1, 0, 9, 0, 1, 0, 5, 0, 1, 1));
        tbl.push_back(idle);

        rst = 1'b1;
        reqA_valid = 0; reqA_wr = 0; reqA_addr = 0; reqA_wdata = 0;
        reqB_valid = 0; reqB_wr = 0; reqB_addr = 0; reqB_wdata = 0;
        cycle(idle, 1'b1);
        cycle(idle, 1'b1);

        for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], 1'b0);

        // reset right after an accept drops the response and clears state
        cycle(mk(1, 1, 6, 8'h05, 0, 0, 0, 0, 1, 1), 1'b0);
        cycle(mk(1, 1, 8, 8'hEE, 1, 1, 8, 8'hDD, 0, 0), 1'b1);
        cycle(idle, 1'b0);
        // priority is back to A after reset
        cycle(mk(1, 1, 8, 8'h01, 1, 1, 8, 8'h02, 1, 0), 1'b0);
        cycle(mk(0, 0, 0, 0, 1, 1, 8, 8'h02, 1, 1), 1'b0);
        cycle(mk(1, 0, 8, 0, 0, 0, 0, 0, 1, 1), 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);

        cmp("qA_drained", qA.size(), 0);
        cmp("qB_drained", qB.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
